// File: rtl/control_ajuste_fecha_hora.sv
// control_ajuste_fecha_hora
// Date/time edit controller: sw_config enters an edit mode where btn_left and
// btn_right pick one of six fields (hora, minuto, segundo, dia, mes, anio) and
// btn_up/btn_down emit one-hot increment/decrement pulses with hold-to-repeat.
// Leaving edit mode issues a single-cycle guardar strobe to commit the values.
// Every output comes straight from a flip-flop.
module control_ajuste_fecha_hora #(
    parameter int HOLD_CYC  = 25_000_000,
    parameter int REP_CYC   = 5_000_000,
    parameter int BLINK_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_config,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [5:0] en_up,
    output logic [5:0] en_down,
    output logic [2:0] campo_sel,
    output logic       modo_config,
    output logic       guardar,
    output logic       parpadeo
);

    localparam int REP_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_CYC + 1);

    // A pulse fires when the count of cycles since the previous pulse reaches
    // threshold, so the thresholds are the periods minus one.
    localparam logic [REP_W-1:0] HOLD_THR  = REP_W'(HOLD_CYC - 1);
    localparam logic [REP_W-1:0] REP_THR   = REP_W'(REP_CYC - 1);
    localparam logic [BLK_W-1:0] BLINK_THR = BLK_W'(BLINK_CYC - 1);

    typedef enum logic [1:0] {NORMAL, EDITANDO, GUARDAR} t_estado;

    t_estado          r_estado;
    logic             r_armed;
    logic             r_sw_q;
    logic             r_up_q;
    logic             r_down_q;
    logic             r_left_q;
    logic             r_right_q;
    logic [1:0]       r_act;
    logic [1:0]       r_first;
    logic [REP_W-1:0] r_cnt [2];
    logic [BLK_W-1:0] r_blk_cnt;

    logic             w_sw_rise;
    logic             w_sw_fall;
    logic             w_enter;
    logic             w_edit;
    logic             w_right;
    logic             w_left;
    logic             w_campo_chg;
    logic             w_both;
    logic             w_any_prev;
    logic [1:0]       w_btn;
    logic [1:0]       w_rise;
    logic [1:0]       w_fire;
    logic [1:0]       w_act_nxt;
    logic [1:0]       w_first_nxt;
    logic [REP_W-1:0] w_cnt_nxt [2];

    // r_armed blocks a spurious entry when sw_config is already high at reset
    // release: a real rising edge needs sw_config to have been seen low first.
    assign w_sw_rise   = sw_config & ~r_sw_q;
    assign w_sw_fall   = ~sw_config & r_sw_q;
    assign w_enter     = (r_estado == NORMAL) & w_sw_rise & r_armed;
    assign w_edit      = (r_estado == EDITANDO) & ~w_sw_fall;
    assign w_right     = btn_right & ~r_right_q;
    assign w_left      = btn_left & ~r_left_q;
    assign w_campo_chg = w_edit & (w_right ^ w_left);
    assign w_both      = btn_up & btn_down;
    assign w_btn       = {btn_down, btn_up};
    assign w_rise      = w_btn & ~{r_down_q, r_up_q};
    assign w_any_prev  = |{en_up, en_down};

    // Previous-cycle copies of every input for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_q    <= 1'b0;
            r_up_q    <= 1'b0;
            r_down_q  <= 1'b0;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
        end else begin
            r_sw_q    <= sw_config;
            r_up_q    <= btn_up;
            r_down_q  <= btn_down;
            r_left_q  <= btn_left;
            r_right_q <= btn_right;
        end
    end

    // Mode FSM with registered modo_config/guardar and the field selector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= NORMAL;
            r_armed     <= 1'b0;
            modo_config <= 1'b0;
            guardar     <= 1'b0;
            campo_sel   <= 3'd0;
        end else begin
            if (!sw_config) r_armed <= 1'b1;
            case (r_estado)
                NORMAL: begin
                    guardar <= 1'b0;
                    if (w_enter) begin
                        r_estado    <= EDITANDO;
                        modo_config <= 1'b1;
                        campo_sel   <= 3'd0;
                    end
                end
                EDITANDO: begin
                    if (w_sw_fall) begin
                        r_estado    <= GUARDAR;
                        modo_config <= 1'b0;
                        guardar     <= 1'b1;
                    end else if (w_campo_chg) begin
                        if (w_right) campo_sel <= (campo_sel == 3'd5) ? 3'd0 : campo_sel + 3'd1;
                        else         campo_sel <= (campo_sel == 3'd0) ? 3'd5 : campo_sel - 3'd1;
                    end
                end
                default: begin
                    r_estado    <= NORMAL;
                    modo_config <= 1'b0;
                    guardar     <= 1'b0;
                end
            endcase
        end
    end

    // Hold-to-repeat decision for up (index 0) and down (index 1). Any abort
    // condition drops the channel to idle so only a fresh rising edge revives
    // it. A pulse due right after another pulse waits one cycle, keeping
    // pulses separated by a low cycle.
    always_comb begin
        w_fire = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_act_nxt[i]   = r_act[i];
            w_first_nxt[i] = r_first[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (!w_edit || w_both || w_campo_chg || !w_btn[i]) begin
                w_act_nxt[i]   = 1'b0;
                w_first_nxt[i] = 1'b0;
                w_cnt_nxt[i]   = '0;
            end else if (w_rise[i]) begin
                w_act_nxt[i] = 1'b1;
                if (!w_any_prev) begin
                    w_fire[i]      = 1'b1;
                    w_first_nxt[i] = 1'b1;
                    w_cnt_nxt[i]   = '0;
                end else begin
                    w_first_nxt[i] = 1'b0;
                    w_cnt_nxt[i]   = REP_THR;
                end
            end else if (r_act[i]) begin
                if (r_cnt[i] >= (r_first[i] ? HOLD_THR : REP_THR)) begin
                    if (!w_any_prev) begin
                        w_fire[i]      = 1'b1;
                        w_first_nxt[i] = 1'b0;
                        w_cnt_nxt[i]   = '0;
                    end
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + REP_W'(1);
                end
            end
        end
    end

    // Repeat state and the registered one-hot pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act    <= 2'b00;
            r_first  <= 2'b00;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
            en_up    <= 6'd0;
            en_down  <= 6'd0;
        end else begin
            r_act    <= w_act_nxt;
            r_first  <= w_first_nxt;
            r_cnt[0] <= w_cnt_nxt[0];
            r_cnt[1] <= w_cnt_nxt[1];
            en_up    <= w_fire[0] ? (6'd1 << campo_sel) : 6'd0;
            en_down  <= w_fire[1] ? (6'd1 << campo_sel) : 6'd0;
        end
    end

    // Blink generator: starts high on entry, toggles every BLINK_CYC cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parpadeo  <= 1'b0;
            r_blk_cnt <= '0;
        end else if (w_enter) begin
            parpadeo  <= 1'b1;
            r_blk_cnt <= '0;
        end else if (w_edit) begin
            if (r_blk_cnt >= BLINK_THR) begin
                parpadeo  <= ~parpadeo;
                r_blk_cnt <= '0;
            end else begin
                r_blk_cnt <= r_blk_cnt + BLK_W'(1);
            end
        end else begin
            parpadeo  <= 1'b0;
            r_blk_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_control_ajuste_fecha_hora.sv
// Directed bench for control_ajuste_fecha_hora with short timing parameters
// (HOLD_CYC=10, REP_CYC=4, BLINK_CYC=3). Inputs change 1 ns after a rising
// edge; outputs are checked at that same point, away from the active edge.
`timescale 1ns/1ps
module tb_control_ajuste_fecha_hora;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_config;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [5:0] en_up;
    logic [5:0] en_down;
    logic [2:0] campo_sel;
    logic       modo_config;
    logic       guardar;
    logic       parpadeo;

    int n_total = 0;
    int n_bad   = 0;

    control_ajuste_fecha_hora #(
        .HOLD_CYC (10),
        .REP_CYC  (4),
        .BLINK_CYC(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_config  (sw_config),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .en_up      (en_up),
        .en_down    (en_down),
        .campo_sel  (campo_sel),
        .modo_config(modo_config),
        .guardar    (guardar),
        .parpadeo   (parpadeo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en_up"}, {26'd0, en_up}, 32'd0);
        chk({tag, "_en_down"}, {26'd0, en_down}, 32'd0);
        chk({tag, "_campo"}, {29'd0, campo_sel}, 32'd0);
        chk({tag, "_modo"}, {31'd0, modo_config}, 32'd0);
        chk({tag, "_guardar"}, {31'd0, guardar}, 32'd0);
        chk({tag, "_parpadeo"}, {31'd0, parpadeo}, 32'd0);
    endtask

    initial begin
        logic [5:0] exp_up;

        // Reset with sw_config already high
        reset = 1'b1; sw_config = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        tick(); tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick(); tick(); tick();
        chk("no_entry_sw_high", {31'd0, modo_config}, 32'd0);

        // Proper entry: sw_config 0 -> 1
        sw_config = 1'b0; tick();
        sw_config = 1'b1; tick();
        chk("enter_modo", {31'd0, modo_config}, 32'd1);
        chk("enter_campo", {29'd0, campo_sel}, 32'd0);
        chk("enter_blink", {31'd0, parpadeo}, 32'd1);
        chk("enter_guardar", {31'd0, guardar}, 32'd0);
        tick(); tick();
        chk("blink_c3", {31'd0, parpadeo}, 32'd1);
        tick();
        chk("blink_c4", {31'd0, parpadeo}, 32'd0);
        tick(); tick(); tick();
        chk("blink_c7", {31'd0, parpadeo}, 32'd1);

        // Field navigation: right x6 then left once
        for (int k = 1; k <= 6; k++) begin
            btn_right = 1'b1; tick();
            chk($sformatf("right_%0d", k), {29'd0, campo_sel}, 32'(k % 6));
            btn_right = 1'b0; tick();
        end
        btn_left = 1'b1; tick();
        chk("left_wrap", {29'd0, campo_sel}, 32'd5);
        btn_left = 1'b0; tick();
        btn_left = 1'b1; tick();
        chk("left_dec", {29'd0, campo_sel}, 32'd4);
        btn_left = 1'b0; tick();
        btn_left = 1'b1; btn_right = 1'b1; tick();
        chk("left_right_same", {29'd0, campo_sel}, 32'd4);
        btn_left = 1'b0; btn_right = 1'b0; tick();

        // Hold btn_up for 30 cycles on field 4
        btn_up = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp_up = (c == 1 || c == 11 || c == 15 || c == 19 || c == 23 || c == 27) ? 6'b010000 : 6'b000000;
            chk($sformatf("hold_up_c%0d", c), {26'd0, en_up}, {26'd0, exp_up});
            chk($sformatf("hold_dn_c%0d", c), {26'd0, en_down}, 32'd0);
        end
        btn_up = 1'b0; tick();
        chk("up_release", {26'd0, en_up}, 32'd0);

        // Up and down together, then release up while down stays held
        btn_up = 1'b1; btn_down = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("both_up_c%0d", c), {26'd0, en_up}, 32'd0);
            chk($sformatf("both_dn_c%0d", c), {26'd0, en_down}, 32'd0);
        end
        btn_up = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("dn_norestart_c%0d", c), {26'd0, en_down}, 32'd0);
        end
        btn_down = 1'b0; tick();

        // btn_down pulse, then field change while held stops repeats
        btn_down = 1'b1; tick();
        chk("down_first", {26'd0, en_down}, 32'h10);
        chk("down_first_up", {26'd0, en_up}, 32'd0);
        tick(); tick();
        chk("down_gap", {26'd0, en_down}, 32'd0);
        btn_right = 1'b1; tick();
        chk("down_sel_change", {29'd0, campo_sel}, 32'd5);
        btn_right = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk($sformatf("down_stopped_c%0d", c), {26'd0, en_down}, 32'd0);
        end
        btn_down = 1'b0; tick();

        // Leave edit mode: one guardar strobe
        sw_config = 1'b0; tick();
        chk("save_guardar", {31'd0, guardar}, 32'd1);
        chk("save_modo", {31'd0, modo_config}, 32'd0);
        chk("save_blink", {31'd0, parpadeo}, 32'd0);
        tick();
        chk("after_guardar", {31'd0, guardar}, 32'd0);
        chk("after_modo", {31'd0, modo_config}, 32'd0);
        tick();
        chk("normal_guardar", {31'd0, guardar}, 32'd0);

        // NORMAL: buttons are ignored
        for (int c = 0; c < 4; c++) begin
            btn_up = (c == 0); btn_down = (c == 1); btn_left = (c == 2); btn_right = (c == 3);
            tick();
            chk($sformatf("norm_up_%0d", c), {26'd0, en_up}, 32'd0);
            chk($sformatf("norm_dn_%0d", c), {26'd0, en_down}, 32'd0);
            chk($sformatf("norm_campo_%0d", c), {29'd0, campo_sel}, 32'd5);
            chk($sformatf("norm_blink_%0d", c), {31'd0, parpadeo}, 32'd0);
            btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
            tick();
        end

        // Reset during edit with btn_up held
        sw_config = 1'b1; tick();
        chk("re_enter_modo", {31'd0, modo_config}, 32'd1);
        chk("re_enter_campo", {29'd0, campo_sel}, 32'd0);
        btn_up = 1'b1; tick();
        chk("re_up_pulse", {26'd0, en_up}, 32'h01);
        tick(); tick();
        #2 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        chk_all_zero("rst_hold");
        reset = 1'b0; sw_config = 1'b0; btn_up = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("post_rst_guardar_%0d", c), {31'd0, guardar}, 32'd0);
            chk($sformatf("post_rst_modo_%0d", c), {31'd0, modo_config}, 32'd0);
            chk($sformatf("post_rst_up_%0d", c), {26'd0, en_up}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
